presc_updown_counter: RTL and testbench
=======================================

# presc_updown_counter

Parametrised up/down counter with a programmable prescaler, programmable wrap limit, synchronous clear and parallel load. It generalises the free-running 4-bit counter into a reusable timing and event-count primitive. Typical uses are timers, baud and tick generators, and frame counters. It sits between the control logic that drives en/dir/load and the consumers of cnt and tc.

## Interface
- WIDTH, 8: counter width in bits (≥1).
- PW, 4: prescaler width in bits (≥1).
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  count enable; advances the prescaler.
- clr  in  1  synchronous clear of counter, prescaler and ovf.
- load  in  1  synchronous parallel load of load_val.
- load_val  in  WIDTH  value loaded into cnt.
- dir  in  1  count direction: 1 = up, 0 = down. Sampled on each tick.
- max_val  in  WIDTH  wrap limit; the counting range is 0..max_val.
- presc  in  PW  the count steps once every presc+1 enabled cycles.
- cnt  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered, high for one cycle per wrap.
- ovf  out  1  sticky wrap flag, registered.

## Operation
- Internal state: pre[PW-1:0] holds the prescaler phase.
- Reset (rst_n low, asynchronous): cnt=0, pre=0, tc=0, ovf=0. All outputs hold these values until the first rising clk edge after rst_n goes high.
- Per-edge priority is clr > load > en.
  - clr: cnt=0, pre=0, tc=0, ovf=0.
  - load (clr low): cnt=load_val, pre=0, tc=0. ovf is unchanged. load_val > max_val is loaded as-is.
  - en (clr and load low): if pre==presc, a tick occurs and pre=0. Otherwise pre=pre+1 and cnt holds.
  - en low: pre, cnt and ovf hold; tc=0.
- On a tick with dir=1 (up):
  - if cnt ≥ max_val: cnt=0, tc=1, ovf=1.
  - else: cnt=cnt+1.
- On a tick with dir=0 (down):
  - if cnt==0: cnt=max_val, tc=1, ovf=1.
  - else: cnt=cnt-1. This applies even when cnt > max_val; no wrap occurs until cnt reaches 0.
- All arithmetic is modulo 2^WIDTH. No value outside 0..2^WIDTH-1 is ever produced.
- Boundary cases:
  - max_val=0: cnt stays 0 and tc pulses on every tick, in either direction.
  - presc=0: a tick occurs on every enabled cycle.
  - presc changed mid-period: the new value is compared immediately. If pre > new presc, pre keeps incrementing and wraps through 2^PW-1 to 0 before a tick occurs.
  - max_val changed mid-count: the new limit applies on the next tick, using the rules above.
  - dir change: takes effect on the next tick. No extra step or skip occurs.
- tc is 0 on every cycle that is not a wrap tick.
- ovf is cleared only by clr or reset.

## Timing
- All outputs are registered. Inputs are sampled at the rising clk edge.
- Load latency: cnt=load_val is visible one cycle after the edge at which load is sampled.
- Tick latency: cnt updates on the same edge at which the tick condition (en && pre==presc) is sampled.
- tc goes high in the same cycle that the wrapped cnt value (0, or max_val when counting down) first appears. It drops after exactly one cycle unless the next tick also wraps.
- With en held high, the tick period is presc+1 cycles and the full wrap period is (max_val+1)*(presc+1) cycles.
- The first tick after reset, clr or load occurs presc+1 enabled cycles later.
- rst_n deassertion must be synchronised externally to clk.

## Test plan
- Reset mid-count: WIDTH=8, max_val=255, presc=0, en=1. Assert rst_n low at cnt=37 -> cnt=0, tc=0 and ovf=0 asynchronously, before the next clk edge.
- Up count with wrap: max_val=9, presc=0, dir=1, en=1 from cnt=0 -> cnt steps 0..9,0. tc=1 only in the cycle cnt returns to 0 (edge 10). ovf=1 from then on.
- Prescaler: presc=3, max_val=255, en=1 -> cnt increments once every 4 cycles. Drop en for 5 cycles mid-period -> pre and cnt hold, and the period resumes where it left off.
- Down count and load: load with load_val=2, dir=0, max_val=5, presc=0 -> cnt sequence 2,1,0,5,4. tc=1 when cnt=5 appears.
- Priority: assert clr, load and en together with load_val=7 -> cnt=0 and ovf=0. Next cycle, assert load and en -> cnt=7 and pre=0.
- Out-of-range values: load 200 with max_val=9, dir=1 -> the next tick gives cnt=0 and tc=1. Then set max_val=0 -> tc=1 on every tick and cnt stays 0.

Source files
------------

// File: rtl/presc_updown_counter.sv
// Up/down counter with programmable prescaler, wrap limit, synchronous clear and load.
// Outputs cnt, tc and ovf are all registered; priority per edge is clr > load > en.
module presc_updown_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic [WIDTH-1:0] max_val,
    input  logic [PW-1:0]    presc,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        pre_d = pre_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = '0;
            pre_d = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            cnt_d = load_val;
            pre_d = '0;
        end else if (en) begin
            // Equality compare: a phase beyond a newly lowered presc wraps through 2^PW-1.
            if (pre_q == presc) begin
                pre_d = '0;
                if (dir) begin
                    if (cnt_q >= max_val) begin
                        cnt_d = '0;
                        tc_d  = 1'b1;
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end else begin
                    if (cnt_q == '0) begin
                        cnt_d = max_val;
                        tc_d  = 1'b1;
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pre_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pre_q <= pre_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_presc_updown_counter.sv
// Scoreboard bench for presc_updown_counter: directed steps push hand-computed
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_presc_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, clr, load, dir;
    logic [7:0] load_val, max_val;
    logic [3:0] presc;
    logic [7:0] cnt;
    logic       tc, ovf;

    typedef struct {
        logic [7:0] cnt;
        logic       tc;
        logic       ovf;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    presc_updown_counter #(.WIDTH(8), .PW(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .max_val  (max_val),
        .presc    (presc),
        .cnt      (cnt),
        .tc       (tc),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Monitor: every negedge, consume all expectations queued since the last one.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (cnt !== e.cnt || tc !== e.tc || ovf !== e.ovf) begin
                bad++;
                $display("FAIL %s: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                         e.nm, cnt, tc, ovf, e.cnt, e.tc, e.ovf);
            end
        end
    end

    task automatic push(input logic [7:0] c, input logic t, input logic o, input string nm);
        exp_t e;
        e.cnt = c;
        e.tc  = t;
        e.ovf = o;
        e.nm  = nm;
        q.push_back(e);
    endtask

    task automatic step(input logic [7:0] c, input logic t, input logic o, input string nm);
        @(posedge clk);
        #1;
        push(c, t, o, nm);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; dir = 1'b1;
        load_val = 8'd0; max_val = 8'd255; presc = 4'd0;

        step(8'd0, 1'b0, 1'b0, "reset");
        rst_n = 1'b1;

        // Free count to 37, then assert reset between edges.
        en = 1'b1;
        for (int i = 1; i <= 36; i++) step(8'(i), 1'b0, 1'b0, "count_to_37");
        adv();
        rst_n = 1'b0;
        #1;
        push(8'd0, 1'b0, 1'b0, "async_reset");
        en = 1'b0;
        step(8'd0, 1'b0, 1'b0, "reset_hold");
        rst_n = 1'b1;

        // Up count with wrap at 9.
        max_val = 8'd9; en = 1'b1;
        for (int i = 1; i <= 9; i++) step(8'(i), 1'b0, 1'b0, "up_count");
        step(8'd0, 1'b1, 1'b1, "up_wrap");
        step(8'd1, 1'b0, 1'b1, "after_wrap");
        en = 1'b0; clr = 1'b1;
        step(8'd0, 1'b0, 1'b0, "clr");
        clr = 1'b0;

        // Prescaler /4 with an en gap mid-period.
        presc = 4'd3; max_val = 8'd255; en = 1'b1;
        for (int i = 0; i < 3; i++) step(8'd0, 1'b0, 1'b0, "presc_hold");
        step(8'd1, 1'b0, 1'b0, "presc_tick");
        step(8'd1, 1'b0, 1'b0, "presc_p1");
        step(8'd1, 1'b0, 1'b0, "presc_p2");
        en = 1'b0;
        for (int i = 0; i < 5; i++) step(8'd1, 1'b0, 1'b0, "en_gap");
        en = 1'b1;
        step(8'd1, 1'b0, 1'b0, "resume_p3");
        step(8'd2, 1'b0, 1'b0, "resume_tick");

        // Load then down count with wrap to max_val.
        presc = 4'd0; load = 1'b1; load_val = 8'd2; dir = 1'b0; max_val = 8'd5;
        step(8'd2, 1'b0, 1'b0, "load2");
        load = 1'b0;
        step(8'd1, 1'b0, 1'b0, "down1");
        step(8'd0, 1'b0, 1'b0, "down0");
        step(8'd5, 1'b1, 1'b1, "down_wrap");
        step(8'd4, 1'b0, 1'b1, "down4");

        // Priority clr > load > en, and load resets the prescaler phase.
        clr = 1'b1; load = 1'b1; load_val = 8'd7; en = 1'b1;
        step(8'd0, 1'b0, 1'b0, "prio_clr");
        clr = 1'b0;
        step(8'd7, 1'b0, 1'b0, "prio_load");
        load = 1'b0; presc = 4'd2; dir = 1'b1; max_val = 8'd255;
        step(8'd7, 1'b0, 1'b0, "pre1");
        load = 1'b1;
        step(8'd7, 1'b0, 1'b0, "reload");
        load = 1'b0;
        step(8'd7, 1'b0, 1'b0, "reload_p1");
        step(8'd7, 1'b0, 1'b0, "reload_p2");
        step(8'd8, 1'b0, 1'b0, "reload_tick");

        // Out-of-range load, then max_val=0 in both directions.
        presc = 4'd0; max_val = 8'd9; en = 1'b0; load = 1'b1; load_val = 8'd200;
        step(8'd200, 1'b0, 1'b0, "load200");
        load = 1'b0; en = 1'b1;
        step(8'd0, 1'b1, 1'b1, "oor_wrap");
        max_val = 8'd0;
        for (int i = 0; i < 3; i++) step(8'd0, 1'b1, 1'b1, "max0_up");
        dir = 1'b0;
        for (int i = 0; i < 2; i++) step(8'd0, 1'b1, 1'b1, "max0_down");

        // Down count above max_val decrements without wrapping.
        en = 1'b0; load = 1'b1; max_val = 8'd9;
        step(8'd200, 1'b0, 1'b1, "load200_dn");
        load = 1'b0; en = 1'b1;
        step(8'd199, 1'b0, 1'b1, "oor_down");

        // presc lowered below the current phase: phase wraps through 15 first.
        clr = 1'b1; dir = 1'b1; max_val = 8'd255;
        step(8'd0, 1'b0, 1'b0, "clr2");
        clr = 1'b0; presc = 4'd3;
        step(8'd0, 1'b0, 1'b0, "pp1");
        step(8'd0, 1'b0, 1'b0, "pp2");
        presc = 4'd1;
        for (int i = 0; i < 15; i++) step(8'd0, 1'b0, 1'b0, "presc_wrap_hold");
        step(8'd1, 1'b0, 1'b0, "presc_wrap_tick");

        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
